// File: rtl/pipeline_arbiter.sv
// Round-robin issue arbiter that shares one in-order ready/valid stage among N_REQ requesters.
// A tag FIFO records each issued requester index so stage results are steered back in order.
module pipeline_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           wk_us_data,
    output logic                       wk_us_valid,
    input  logic                       wk_us_ready,
    input  logic [WIDTH-1:0]           wk_ds_data,
    input  logic                       wk_ds_valid,
    output logic                       wk_ds_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       err
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(N_REQ - 1);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [TAG_W-1:0] grant;
    logic [TAG_W:0]   cand;
    logic             found;
    logic [TAG_W-1:0] head;
    logic             full, empty, push, pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = tag_mem_q[rd_ptr_q];

    // Search starts at rr_ptr and wraps; the extra bit in cand absorbs the overflow before folding.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(N_REQ)) begin
                cand = cand - (TAG_W+1)'(N_REQ);
            end
            if (!found && req_valid[cand[TAG_W-1:0]]) begin
                found = 1'b1;
                grant = cand[TAG_W-1:0];
            end
        end
    end

    // Outputs are gated by reset_n so they read idle while reset is held.
    always_comb begin
        wk_us_valid = reset_n && (|req_valid) && !full;
        wk_us_data  = wk_us_valid ? req_data[int'(grant)*WIDTH +: WIDTH] : '0;
        req_ready   = '0;
        if (reset_n && found && wk_us_ready && !full) begin
            req_ready[grant] = 1'b1;
        end
        wk_ds_ready = reset_n && !empty && rsp_ready[head];
        rsp_valid   = '0;
        if (reset_n && wk_ds_valid && !empty) begin
            rsp_valid[head] = 1'b1;
        end
    end

    assign rsp_data    = wk_ds_data;
    assign outstanding = cnt_q;
    assign err         = err_q;

    assign push = wk_us_valid && wk_us_ready;
    assign pop  = wk_ds_valid && wk_ds_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            rr_ptr_d = (grant == LAST_TAG) ? '0 : grant + TAG_W'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        err_d = err_q | (wk_ds_valid && empty);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Tag storage is only read while occupied, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant;
        end
    end

endmodule
